// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage.
package mips_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/mips_imem.sv
// Instruction memory: combinational read and synchronous write, with no reset so
// that a program loaded before or during reset is kept.
module mips_imem
  import mips_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A write and a fetch of the same word in one cycle return the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_fetch_stage.sv
// Fetch stage: PC, instruction memory and the IF/ID register, with stall,
// redirect and fault-halt handling.
//   state | meaning
//   RUN   | fetching; redirect > stall > sequential fetch
//   HALT  | fault seen; PC and IF/ID frozen until an aligned redirect
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   pc,
  output logic [31:0]                   if_id_instr,
  output logic [31:0]                   if_id_pc4,
  output logic                          if_id_valid,
  output logic                          halted,
  output logic                          fault_misaligned,
  output logic                          fault_range
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_nxt, instr_nxt, pc4_nxt;
  logic         valid_nxt, fm_nxt, fr_nxt;
  logic [31:0]  imem_rdata;
  logic [31:0]  pc_plus4;
  logic         in_range;
  logic         redirect_misaligned;

  mips_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc[AW+1:2]),
    .rdata (imem_rdata)
  );

  assign pc_plus4            = pc + 32'd4;
  assign in_range            = pc[31:2] < 30'(IMEM_DEPTH);
  assign redirect_misaligned = redirect_pc[1:0] != 2'b00;
  assign halted              = state == HALT;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = if_id_instr;
    pc4_nxt   = if_id_pc4;
    valid_nxt = if_id_valid;
    fm_nxt    = fault_misaligned;
    fr_nxt    = fault_range;
    unique case (state)
      RUN: begin
        if (redirect_valid) begin
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
          if (redirect_misaligned) begin
            fm_nxt    = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt = redirect_pc;
          end
        end else if (!stall) begin
          if (in_range) begin
            instr_nxt = imem_rdata;
            pc4_nxt   = pc_plus4;
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
          end else begin
            fr_nxt    = 1'b1;
            state_nxt = HALT;
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
          end
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
        if (redirect_valid) begin
          if (redirect_misaligned) begin
            fm_nxt = 1'b1;
          end else begin
            fm_nxt    = 1'b0;
            fr_nxt    = 1'b0;
            pc_nxt    = redirect_pc;
            state_nxt = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      pc               <= RESET_PC;
      if_id_instr      <= NOP_INSTR;
      if_id_pc4        <= 32'h0;
      if_id_valid      <= 1'b0;
      fault_misaligned <= 1'b0;
      fault_range      <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      if_id_instr      <= instr_nxt;
      if_id_pc4        <= pc4_nxt;
      if_id_valid      <= valid_nxt;
      fault_misaligned <= fm_nxt;
      fault_range      <= fr_nxt;
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios then random traffic against a
// behavioural fetch model.
module tb_mips_fetch_stage;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_we = 1'b0;
  logic [4:0]  imem_waddr = 5'd0;
  logic [31:0] imem_wdata = 32'h0;
  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted, fault_misaligned, fault_range;

  mips_fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_we          (imem_we),
    .imem_waddr       (imem_waddr),
    .imem_wdata       (imem_wdata),
    .pc               (pc),
    .if_id_instr      (if_id_instr),
    .if_id_pc4        (if_id_pc4),
    .if_id_valid      (if_id_valid),
    .halted           (halted),
    .fault_misaligned (fault_misaligned),
    .fault_range      (fault_range)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt, m_fm, m_fr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_fm = 1'b0; m_fr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},     pc,               m_pc);
    check({tag, ".instr"},  if_id_instr,      m_instr);
    check({tag, ".pc4"},    if_id_pc4,        m_pc4);
    check({tag, ".valid"},  32'(if_id_valid), 32'(m_valid));
    check({tag, ".halted"}, 32'(halted),      32'(m_halt));
    check({tag, ".fm"},     32'(fault_misaligned), 32'(m_fm));
    check({tag, ".fr"},     32'(fault_range), 32'(m_fr));
  endtask

  // Fetch semantics: redirect beats stall; faults freeze the stage until an aligned redirect.
  task automatic model_edge(input bit st, input bit rv, input logic [31:0] rpc,
                            input bit we, input logic [4:0] wa, input logic [31:0] wd);
    bit aligned;
    aligned = (rpc % 4) == 0;
    if (m_halt) begin
      m_valid = 1'b0;
      if (rv && !aligned) m_fm = 1'b1;
      else if (rv) begin
        m_fm = 1'b0; m_fr = 1'b0; m_pc = rpc; m_halt = 1'b0;
      end
    end else if (rv) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (aligned) m_pc = rpc;
      else begin m_fm = 1'b1; m_halt = 1'b1; end
    end else if (!st) begin
      if (m_pc / 4 < DEPTH) begin
        m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
      end else begin
        m_fr = 1'b1; m_halt = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
      end
    end
    if (we) mem[wa] = wd;
  endtask

  task automatic step(input string tag, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    model_edge(st, rv, rpc, we, wa, wd);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic redir(input string tag, input logic [31:0] rpc, input bit st);
    step(tag, st, 1'b1, rpc, 1'b0, 5'd0, 32'h0);
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h20010005; prog[1] = 32'h20020003;
    prog[2] = 32'h00221820; prog[3] = 32'hAC030000;
    model_reset();

    // program load while held in reset
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = 5'(i);
      imem_wdata = (i < 4) ? prog[i] : $urandom;
      mem[i] = imem_wdata;
    end
    @(negedge clk);
    imem_we = 1'b0;
    #1;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sequential fetch from the reset PC (first edge after release above fetched imem[0])
    model_edge(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_all("seq1");
    check("seq1.instr_const", if_id_instr, 32'h20010005);
    for (int i = 2; i <= 4; i++) idle($sformatf("seq%0d", i));
    check("seq4.instr_const", if_id_instr, 32'hAC030000);
    check("seq4.pc_const", pc, 32'd16);

    // restart at 0, two fetches, then three stalled cycles
    redir("restart", 32'h0, 1'b0);
    idle("f1");
    idle("f2");
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("stall.instr_const", if_id_instr, 32'h20020003);
    check("stall.pc_const", pc, 32'd8);
    idle("unstall");
    check("unstall.instr_const", if_id_instr, 32'h00221820);

    // redirect wins over simultaneous stall; one bubble
    redir("redir_stall", 32'h40, 1'b1);
    check("redir.pc_const", pc, 32'h40);
    idle("redir_tgt");
    check("redir_tgt.pc4_const", if_id_pc4, 32'h44);

    // misaligned redirect halts; aligned redirect recovers
    redir("misal", 32'h42, 1'b0);
    check("misal.halted_const", 32'(halted), 32'd1);
    step("halt_stall", 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    redir("misal_again", 32'h43, 1'b0);
    redir("recover", 32'h0, 1'b0);
    idle("recover_fetch");
    check("recover.instr_const", if_id_instr, 32'h20010005);

    // last word then range fault
    redir("to_end", 32'h7C, 1'b0);
    idle("last_word");
    idle("range");
    check("range.pc_const", pc, 32'h80);
    check("range.fr_const", 32'(fault_range), 32'd1);
    idle("range_hold");

    // async reset mid-cycle while halted
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst");
    check("post_rst.instr_const", if_id_instr, 32'h20010005);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      bit st, rv, we;
      logic [31:0] rpc;
      int sel;
      st = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 15);
      sel = $urandom_range(0, 99);
      if (sel < 60)      rpc = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel < 75) rpc = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (sel < 90) rpc = 32'($urandom_range(DEPTH - 3, DEPTH - 1)) * 4;
      else               rpc = $urandom & 32'hFFFF_FFFC;
      we = ($urandom_range(0, 99) < 20);
      step("rand", st, rv, rpc, we, 5'($urandom_range(0, DEPTH - 1)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction Fetch (IF) stage plus IF/ID pipeline register of the MIPS pipelined processor.
- Holds the PC and reads a word-addressed instruction memory.
- Registers the instruction and PC+4 into IF/ID, where they drive the decode/execute datapath's Instruction input.
- Honours a stall from hazard logic, takes redirects for branches and jumps, and halts on fetch faults.

Parameters:
- IMEM_DEPTH, 32, number of 32-bit instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and IF/ID contents.
- redirect_valid  input  1  branch taken or jump resolved downstream.
- redirect_pc  input  32  new fetch address when redirect_valid=1.
- imem_we  input  1  instruction memory write enable (program load).
- imem_waddr  input  $clog2(IMEM_DEPTH)  word index to write.
- imem_wdata  input  32  word to write.
- pc  output  32  current fetch address.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  stage is in HALT.
- fault_misaligned  output  1  sticky: a redirect target had bits[1:0] != 0.
- fault_range  output  1  sticky: fetch word index >= IMEM_DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - pc=RESET_PC, state=RUN;
  - if_id_instr=NOP (32'h0), if_id_pc4=0, if_id_valid=0;
  - both faults=0, halted=0.
  - Instruction memory contents are not cleared.
- Memory read is combinational on word index pc[31:2]. Memory write is synchronous. A same-cycle write and fetch to the same word returns the old data.
- States: RUN and HALT. halted = (state==HALT).
- RUN, per rising edge, with priority redirect > stall > normal:
  - redirect_valid=1:
    - if redirect_pc[1:0]!=0: fault_misaligned=1, state=HALT, pc unchanged.
    - otherwise: pc=redirect_pc.
    - In both cases IF/ID is flushed: instr=NOP, valid=0. A redirect overrides a simultaneous stall.
  - stall=1 (no redirect): pc, if_id_instr, if_id_pc4 and if_id_valid all hold.
  - normal, with pc[31:2] < IMEM_DEPTH: if_id_instr=imem[pc[31:2]], if_id_pc4=pc+4, if_id_valid=1, pc=pc+4.
  - normal, with pc[31:2] >= IMEM_DEPTH: fault_range=1, state=HALT, IF/ID flushed, pc holds.
- HALT:
  - pc and IF/ID hold; if_id_valid=0.
  - A valid aligned redirect clears both faults, loads pc=redirect_pc and returns to RUN.
  - A misaligned redirect keeps HALT and sets fault_misaligned.
  - stall is ignored.
- Arithmetic: pc+4 is 32-bit modulo. Wrap from 32'hFFFF_FFFC to 0 is legal but is caught earlier by the range check.
- Latency: one cycle from pc to IF/ID. A redirect produces exactly one bubble: the first instruction from the target appears in IF/ID on the second edge after redirect.
- Reset mid-stall or mid-HALT returns immediately to the reset values listed above.

Decomposition:
- Package mips_pkg:
  - constants: WORD_W=32, NOP_INSTR=32'h0000_0000;
  - fetch_state_t enum {RUN, HALT}.
- One sub-module, mips_imem: IMEM_DEPTH x 32 array with a combinational read port and a synchronous write port. Instantiated once.
- PC, IF/ID register and FSM live in mips_fetch_stage.

Test Plan:
- Reset release and sequential fetch:
  - Stimulus: load imem[0..3]=32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030000; release reset.
  - Response: edges 1-4 give if_id_instr in that order, if_id_pc4=4,8,12,16, valid=1, final pc=16.
- Stall:
  - Stimulus: assert stall for 3 cycles after the 2nd fetch.
  - Response: if_id_instr stays 32'h20020003, pc stays 8. After release the next edge gives 32'h00221820.
- Redirect:
  - Stimulus: redirect_valid=1, redirect_pc=32'h0000_0040, with stall=1 in the same cycle.
  - Response: next edge gives valid=0, instr=0, pc=0x40. The following edge gives if_id_instr=imem[16], if_id_pc4=0x44.
- Misaligned redirect:
  - Stimulus: redirect_pc=32'h0000_0042.
  - Response: fault_misaligned=1, halted=1, pc unchanged, valid=0. Then redirect_pc=0x0 gives faults cleared, RUN, fetch of imem[0].
- Range fault:
  - Stimulus: IMEM_DEPTH=32, redirect to 0x7C, no stall.
  - Response: imem[31] is fetched; on the next edge fault_range=1, halted=1, valid=0, pc=0x80 held.
- Asynchronous reset:
  - Stimulus: drop rst_n mid-cycle during HALT.
  - Response: outputs go to reset values before the next clock edge. imem contents are preserved, so the first fetch after release is imem[0].
